// File: rtl/decoder_2to4_hs.sv
// 2-to-4 one-hot decoder behind a 2-entry valid/ready skid buffer.
// Entries are stored already decoded so the outputs come straight off flops.
module decoder_2to4_hs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Y,
    input  logic       V,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       D3,
    output logic       D2,
    output logic       D1,
    output logic       D0,
    output logic       none,
    output logic       out_valid,
    input  logic       out_ack,
    output logic [7:0] dec_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic       none;
        logic [3:0] d;
    } entry_t;

    function automatic entry_t decode(input logic [1:0] y, input logic v);
        entry_t e;
        e.none = ~v;
        e.d    = v ? (4'b0001 << y) : 4'b0000;
        return e;
    endfunction

    state_t     state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic [7:0] cnt_q, cnt_d;
    entry_t     new_entry;
    logic       accept, consume;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ack;
    assign new_entry = decode(Y, V);

    // head is cleared whenever the buffer drains, so an empty block shows 0000 / none=0
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (consume && !head_q.none && cnt_q != 8'hff)
            cnt_d = cnt_q + 8'd1;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({accept, consume})
                    2'b10: begin
                        skid_d  = new_entry;
                        state_d = TWO;
                    end
                    2'b01: begin
                        head_d  = '0;
                        state_d = EMPTY;
                    end
                    2'b11:   head_d = new_entry;
                    default: ;
                endcase
            end
            TWO: begin
                if (consume) begin
                    head_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                head_d  = '0;
                skid_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {none, D3, D2, D1, D0} = head_q;
    assign dec_count              = cnt_q;

endmodule

// File: tb/tb_decoder_2to4_hs.sv
// Scoreboard bench for decoder_2to4_hs: expected decodes queue on accept, pop on consume.
module tb_decoder_2to4_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] Y;
    logic       V;
    logic       in_valid;
    logic       in_ready;
    logic       D3, D2, D1, D0, none;
    logic       out_valid;
    logic       out_ack;
    logic [7:0] dec_count;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cnt   = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    decoder_2to4_hs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Y         (Y),
        .V         (V),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D3        (D3),
        .D2        (D2),
        .D1        (D1),
        .D0        (D0),
        .none      (none),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .dec_count (dec_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // {none, D3, D2, D1, D0}
    function automatic logic [4:0] model_dec(input logic [1:0] y, input logic v);
        if (!v) return 5'b10000;
        case (y)
            2'd0:    return 5'b00001;
            2'd1:    return 5'b00010;
            2'd2:    return 5'b00100;
            default: return 5'b01000;
        endcase
    endfunction

    // Called just after a negedge: drive, check outputs, cross the posedge, update model.
    task automatic step(input logic iv, input logic [1:0] y, input logic v,
                        input logic ack, input logic rn);
        logic       rdy_e, acc, con;
        logic [4:0] exp_out;
        in_valid = iv;
        Y        = y;
        V        = v;
        out_ack  = ack;
        rst_n    = rn;
        #1;
        rdy_e   = (sb_q.size() < 2);
        exp_out = 5'b00000;
        if (sb_q.size() != 0) exp_out = sb_q[0];
        chk("in_ready", in_ready, rdy_e);
        chk("out_valid", out_valid, sb_q.size() != 0);
        chk("dout", {none, D3, D2, D1, D0}, exp_out);
        chk("dec_count", dec_count, cnt);
        acc = iv && rdy_e;
        con = ack && (sb_q.size() != 0);
        @(posedge clk);
        if (!rn) begin
            sb_q.delete();
            cnt = 0;
        end else begin
            if (con) begin
                if (!sb_q[0][4] && cnt != 255) cnt++;
                void'(sb_q.pop_front());
            end
            if (acc) sb_q.push_back(model_dec(y, v));
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid = 1'b0;
        Y        = 2'd0;
        V        = 1'b0;
        out_ack  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset held: idle outputs
        step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // single decode
        step(1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
        chk("single_d", {none, D3, D2, D1, D0}, 5'b00100);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // V=0 entry
        step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // backpressure with in_valid held while full
        step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // full-rate streaming
        for (int i = 0; i < 6; i++)
            step(1'b1, 2'(i % 4), 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // random traffic including stray acks on an empty buffer
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        // saturation: 260+ V=1 consumes
        for (int i = 0; i < 262; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("saturate", dec_count, 32'd255);

        // reset while full, with ack asserted
        step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_count", dec_count, 32'd0);
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_d", {none, D3, D2, D1, D0}, 5'b00010);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_2to4_hs.md
DECODER_2TO4_HS -- requirements
Module: decoder_2to4_hs

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, as listed first below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 Y  input  2  encoded index of the highest-priority active line (3 = D3 … 0 = D0).
REQ-005 V  input  1  code-valid flag; 0 means no line was active.
REQ-006 in_valid  input  1  upstream presents {Y,V} this cycle.
REQ-007 in_ready  output  1  block can accept {Y,V} this cycle.
REQ-008 D3, D2, D1, D0  output  1 each  registered one-hot decode of the head entry.
REQ-009 none  output  1  head entry carried V=0.
REQ-010 out_valid  output  1  D3..D0 and none hold a valid head entry.
REQ-011 out_ack  input  1  downstream consumes the head entry this cycle.
REQ-012 dec_count  output  8  count of consumed entries with V=1, saturating.

Function
REQ-013 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; {Y,V} is sampled only on accept.
REQ-014 Consume SHALL occur on a rising edge where out_valid=1 and out_ack=1; out_ack with out_valid=0 SHALL be ignored.
REQ-015 Storage SHALL be 2 entries: a head (output) register and one skid register, tracked by FSM states EMPTY, ONE, TWO.
REQ-016 Outputs SHALL be: in_ready = (state != TWO); out_valid = (state != EMPTY).
REQ-017 Decode of an entry SHALL be:
- V=1: exactly the bit selected by Y is 1, the other three are 0, none=0.
- V=0: D3..D0 = 0000, none=1, Y ignored.
REQ-018 Latency: an entry accepted into EMPTY SHALL appear on D3..D0/none with out_valid=1 in the cycle immediately after the accept edge.
REQ-019 EMPTY transitions: accept -> ONE, entry loaded into head; no accept -> EMPTY.
REQ-020 ONE transitions:
- accept without consume -> TWO, entry loaded into skid.
- consume without accept -> EMPTY.
- accept and consume on the same edge -> ONE, head replaced by the new entry.
- neither -> ONE.
REQ-021 TWO transitions: consume -> ONE, skid moved to head; no consume -> TWO; in_valid is ignored because in_ready=0.
REQ-022 Ordering: entries SHALL be presented in accept order, with none lost or duplicated.
REQ-023 While out_valid=1 and no consume occurs, head outputs SHALL remain stable.
REQ-024 When out_valid=0, D3..D0 SHALL be 0000 and none SHALL be 0.
REQ-025 dec_count SHALL increment by 1 on each consume whose entry had V=1, hold at 255 (no wrap), and not change on V=0 consumes.

Reset
REQ-026 On a rising edge with rst_n=0, state SHALL become EMPTY and head and skid SHALL be cleared.
REQ-027 Output values during and after reset SHALL be: in_ready=1, out_valid=0, D3..D0=0000, none=0, dec_count=0.
REQ-028 Reset SHALL take priority over a simultaneous accept or consume; any in-flight entries are discarded.
REQ-029 After the first edge with rst_n=1, operation SHALL follow REQ-013 to REQ-025 with no extra idle cycle.

Verification
REQ-030 Single decode: reset; accept Y=2,V=1; out_ack=1 one cycle later.
- Expected: next cycle D3..D0=0100, none=0, out_valid=1.
- Expected after consume: out_valid=0, dec_count=1.
REQ-031 No-input code: accept Y=3,V=0.
- Expected: D3..D0=0000, none=1, out_valid=1.
- Expected after consume: dec_count=0.
REQ-032 Backpressure: out_ack=0; accept Y=0,V=1 then Y=3,V=1.
- Expected: in_ready=0 with in_valid held; outputs 0001.
- Then one ack: outputs 1000, in_ready=1.
- Then one ack: out_valid=0.
REQ-033 Full-rate streaming: in_valid=1 and out_ack=1 every cycle with Y=0,1,2,3,0,1 and V=1.
- Expected: outputs 0001, 0010, 0100, 1000, 0001, 0010 on consecutive cycles.
- Expected: in_ready stays 1 and state stays ONE.
REQ-034 Saturation: perform 260 V=1 consumes; dec_count reaches 255 and stays 255.
REQ-035 Reset mid-operation: in state TWO, drive rst_n=0 for one edge with out_ack=1.
- Expected after the edge: out_valid=0, in_ready=1, dec_count=0.
- Expected: the next accept Y=1,V=1 yields 0010.
